// File: rtl/regfile_sb_if.sv
// Register-file access bus: write port, two read ports and the scoreboard reserve/busy signals.
// Latency: none of its own; it only carries signals between issue logic and regfile_sb.
// Backpressure: ReserveAck refuses a reservation on a register that is already pending; reads and writes are never stalled.
interface regfile_sb_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] WriteRegister;
  logic [WIDTH-1:0]      WriteData;
  logic [ADDR_WIDTH-1:0] ReadRegister1;
  logic [ADDR_WIDTH-1:0] ReadRegister2;
  logic [WIDTH-1:0]      ReadData1;
  logic [WIDTH-1:0]      ReadData2;
  logic                  Reserve;
  logic [ADDR_WIDTH-1:0] ReserveRegister;
  logic                  ReserveAck;
  logic                  Busy1;
  logic                  Busy2;

  // Issue-logic side
  modport master (
    output RegWrite, WriteRegister, WriteData,
    output ReadRegister1, ReadRegister2,
    output Reserve, ReserveRegister,
    input  ReadData1, ReadData2, ReserveAck, Busy1, Busy2
  );

  // Register-file side
  modport slave (
    input  RegWrite, WriteRegister, WriteData,
    input  ReadRegister1, ReadRegister2,
    input  Reserve, ReserveRegister,
    output ReadData1, ReadData2, ReserveAck, Busy1, Busy2
  );
endinterface

// File: rtl/regfile_sb.sv
// Register file (r0 hard-wired to zero) with two async read ports, one sync write port and a pending-write scoreboard.
// Latency: writes and scoreboard updates visible one edge later; with REGFILE_BYPASS_EN a write is forwarded to reads in the same cycle.
// Backpressure: reserving an already-pending register (or r0) is refused via ReserveAck=0; issue logic retries.
module regfile_sb #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5
) (
  input logic         Clk,
  input logic         ResetN,
  regfile_sb_if.slave bus
);
  localparam int NREGS = 2 ** ADDR_WIDTH;

  // r0 has no storage; only 1..NREGS-1 are real flops
  logic [WIDTH-1:0] regs [1:NREGS-1];
  logic [NREGS-1:1] pending;

  // Zero-extended views so address 0 can be indexed without a special case at each read site
  logic [WIDTH-1:0] reg_view [0:NREGS-1];
  logic [NREGS-1:0] pend_view;

  logic write_hit;
  logic reserve_ok;

  // Build 0..NREGS-1 views with r0 tied to zero and never pending
  always_comb begin
    reg_view[0]  = '0;
    pend_view[0] = 1'b0;
    for (int i = 1; i < NREGS; i++) begin
      reg_view[i]  = regs[i];
      pend_view[i] = pending[i];
    end
  end

  assign write_hit  = bus.RegWrite && (bus.WriteRegister != '0);
  // Evaluated against the pre-edge pending bit, so a same-edge write cannot unblock it
  assign reserve_ok = bus.Reserve && (bus.ReserveRegister != '0) && !pend_view[bus.ReserveRegister];
  assign bus.ReserveAck = reserve_ok;

  // Storage and scoreboard update; a fresh reservation outranks the clear from a write
  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      for (int i = 1; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      pending <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (write_hit && (bus.WriteRegister == ADDR_WIDTH'(i))) begin
          regs[i] <= bus.WriteData;
        end
        if (reserve_ok && (bus.ReserveRegister == ADDR_WIDTH'(i))) begin
          pending[i] <= 1'b1;
        end else if (write_hit && (bus.WriteRegister == ADDR_WIDTH'(i))) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1;
  logic fwd2;

  assign fwd1 = write_hit && (bus.ReadRegister1 == bus.WriteRegister);
  assign fwd2 = write_hit && (bus.ReadRegister2 == bus.WriteRegister);

  // Read ports with write-through forwarding; a forwarded register is reported not busy
  always_comb begin
    bus.ReadData1 = fwd1 ? bus.WriteData : reg_view[bus.ReadRegister1];
    bus.ReadData2 = fwd2 ? bus.WriteData : reg_view[bus.ReadRegister2];
    bus.Busy1     = fwd1 ? 1'b0 : pend_view[bus.ReadRegister1];
    bus.Busy2     = fwd2 ? 1'b0 : pend_view[bus.ReadRegister2];
  end
`else
  // Read ports reflect stored state only, one edge behind the write
  always_comb begin
    bus.ReadData1 = reg_view[bus.ReadRegister1];
    bus.ReadData2 = reg_view[bus.ReadRegister2];
    bus.Busy1     = pend_view[bus.ReadRegister1];
    bus.Busy2     = pend_view[bus.ReadRegister2];
  end
`endif
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset state, write/read isolation, scoreboard reserve/clear, bypass timing, reset flush.
// Latency: inputs change #1 after posedge, outputs checked #1 later, well away from the active edge.
// Backpressure: exercises ReserveAck refusal on pending registers and r0.
module tb_regfile_sb;
  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;

  logic Clk;
  logic ResetN;
  int   vecs;
  int   miscompares;

  regfile_sb_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  regfile_sb #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .Clk    (Clk),
    .ResetN (ResetN),
    .bus    (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge, then drop the one-shot controls and let outputs settle
  task automatic tick();
    @(posedge Clk);
    #1;
    bus.RegWrite = 1'b0;
    bus.Reserve  = 1'b0;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    bus.RegWrite      = 1'b1;
    bus.WriteRegister = a;
    bus.WriteData     = d;
    tick();
  endtask

  initial begin
    vecs = 0;
    miscompares = 0;
    // Reset with write/reserve asserted: both must be ignored
    ResetN              = 1'b0;
    bus.RegWrite        = 1'b1;
    bus.WriteRegister   = 5'd4;
    bus.WriteData       = 32'h1234_5678;
    bus.ReadRegister1   = '0;
    bus.ReadRegister2   = '0;
    bus.Reserve         = 1'b1;
    bus.ReserveRegister = 5'd4;
    tick();
    tick();
    ResetN = 1'b1;
    #1;

    for (int a = 0; a < 32; a++) begin
      bus.ReadRegister1 = 5'(a);
      bus.ReadRegister2 = 5'(31 - a);
      #1;
      check("rst_rd1", bus.ReadData1, 32'd0);
      check("rst_rd2", bus.ReadData2, 32'd0);
      check("rst_busy1", {31'd0, bus.Busy1}, 32'd0);
      check("rst_busy2", {31'd0, bus.Busy2}, 32'd0);
    end

    // Overwrite r2, verify neighbours untouched
    wr(5'd2, 32'd42);
    bus.ReadRegister1 = 5'd2; bus.ReadRegister2 = 5'd2; #1;
    check("r2_42_p1", bus.ReadData1, 32'd42);
    check("r2_42_p2", bus.ReadData2, 32'd42);
    wr(5'd2, 32'd15);
    check("r2_15_p1", bus.ReadData1, 32'd15);
    check("r2_15_p2", bus.ReadData2, 32'd15);
    bus.ReadRegister1 = 5'd1; bus.ReadRegister2 = 5'd3; #1;
    check("r1_iso", bus.ReadData1, 32'd0);
    check("r3_iso", bus.ReadData2, 32'd0);

    // Disabled write and write to r0
    bus.RegWrite = 1'b0; bus.WriteRegister = 5'd2; bus.WriteData = 32'd30;
    tick();
    bus.ReadRegister1 = 5'd2; #1;
    check("we0_r2", bus.ReadData1, 32'd15);
    wr(5'd0, 32'd15);
    bus.ReadRegister1 = 5'd0; #1;
    check("r0_zero", bus.ReadData1, 32'd0);
    check("r0_busy", {31'd0, bus.Busy1}, 32'd0);

    // Independent ports
    wr(5'd17, 32'd30);
    bus.ReadRegister1 = 5'd2; bus.ReadRegister2 = 5'd17; #1;
    check("port1_r2", bus.ReadData1, 32'd15);
    check("port2_r17", bus.ReadData2, 32'd30);

    // Same-cycle read of a register being written
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd9; bus.WriteData = 32'hDEAD_BEEF;
    bus.ReadRegister1 = 5'd9; #1;
`ifdef REGFILE_BYPASS_EN
    check("r9_same_cycle", bus.ReadData1, 32'hDEAD_BEEF);
`else
    check("r9_same_cycle", bus.ReadData1, 32'd0);
`endif
    tick();
    check("r9_after_edge", bus.ReadData1, 32'hDEAD_BEEF);

    // Reserve r5, refused retry, then cleared by write
    bus.Reserve = 1'b1; bus.ReserveRegister = 5'd5; bus.ReadRegister1 = 5'd5; #1;
    check("rsv5_ack", {31'd0, bus.ReserveAck}, 32'd1);
    check("rsv5_busy_pre", {31'd0, bus.Busy1}, 32'd0);
    tick();
    check("rsv5_busy", {31'd0, bus.Busy1}, 32'd1);
    bus.Reserve = 1'b1; #1;
    check("rsv5_again_ack", {31'd0, bus.ReserveAck}, 32'd0);
    tick();
    check("rsv5_still_busy", {31'd0, bus.Busy1}, 32'd1);
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd5; bus.WriteData = 32'd7; #1;
`ifdef REGFILE_BYPASS_EN
    check("wr5_busy_pre", {31'd0, bus.Busy1}, 32'd0);
`else
    check("wr5_busy_pre", {31'd0, bus.Busy1}, 32'd1);
`endif
    tick();
    check("wr5_busy", {31'd0, bus.Busy1}, 32'd0);
    check("wr5_data", bus.ReadData1, 32'd7);

    // Same-edge write + reserve on r6: reservation wins
    bus.RegWrite = 1'b1; bus.WriteRegister = 5'd6; bus.WriteData = 32'd99;
    bus.Reserve = 1'b1; bus.ReserveRegister = 5'd6; bus.ReadRegister2 = 5'd6; #1;
    check("r6_ack", {31'd0, bus.ReserveAck}, 32'd1);
    check("r6_busy_pre", {31'd0, bus.Busy2}, 32'd0);
    tick();
    check("r6_busy", {31'd0, bus.Busy2}, 32'd1);
    check("r6_data", bus.ReadData2, 32'd99);

    // Reserve r0 is always refused
    bus.Reserve = 1'b1; bus.ReserveRegister = 5'd0; #1;
    check("rsv0_ack", {31'd0, bus.ReserveAck}, 32'd0);
    tick();

    // Write to non-pending register leaves it not busy
    wr(5'd3, 32'd3);
    bus.ReadRegister1 = 5'd3; #1;
    check("r3_data", bus.ReadData1, 32'd3);
    check("r3_busy", {31'd0, bus.Busy1}, 32'd0);

    // Re-reserve r5, then reset flushes storage and scoreboard
    bus.Reserve = 1'b1; bus.ReserveRegister = 5'd5; tick();
    bus.ReadRegister1 = 5'd5; #1;
    check("r5_busy_pre_rst", {31'd0, bus.Busy1}, 32'd1);
    ResetN = 1'b0;
    tick();
    ResetN = 1'b1; #1;
    bus.ReadRegister1 = 5'd5; bus.ReadRegister2 = 5'd6; #1;
    check("rst_r5_busy", {31'd0, bus.Busy1}, 32'd0);
    check("rst_r6_busy", {31'd0, bus.Busy2}, 32'd0);
    check("rst_r5_data", bus.ReadData1, 32'd0);
    bus.ReadRegister1 = 5'd9; bus.ReadRegister2 = 5'd17; #1;
    check("rst_r9_data", bus.ReadData1, 32'd0);
    check("rst_r17_data", bus.ReadData2, 32'd0);
    bus.Reserve = 1'b1; bus.ReserveRegister = 5'd5; #1;
    check("rst_rsv5_ack", {31'd0, bus.ReserveAck}, 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with two asynchronous read ports, one synchronous write port, a hard-wired zero register and a per-register pending-write scoreboard. It is the next-generation core-datapath register file: width and depth are generic, all state is cleared by synchronous reset, and it tracks registers whose results are still in flight so issue logic can stall on hazards. An optional write-to-read bypass is compiled in by macro.

## Interface
- WIDTH, 32, data word width in bits (≥1)
- ADDR_WIDTH, 5, register address width; register count NREGS = 2**ADDR_WIDTH (≥2)

- Clk  input  1  clock, all state updates on posedge
- ResetN  input  1  synchronous, active-low reset, sampled on posedge Clk
- RegWrite  input  1  write enable
- WriteRegister  input  ADDR_WIDTH  write address
- WriteData  input  WIDTH  write data
- ReadRegister1  input  ADDR_WIDTH  read port 1 address
- ReadRegister2  input  ADDR_WIDTH  read port 2 address
- ReadData1  output  WIDTH  read port 1 data
- ReadData2  output  WIDTH  read port 2 data
- Reserve  input  1  request to mark ReserveRegister pending
- ReserveRegister  input  ADDR_WIDTH  register to reserve
- ReserveAck  output  1  reservation accepted this cycle (combinational)
- Busy1  output  1  register at ReadRegister1 is pending
- Busy2  output  1  register at ReadRegister2 is pending

## Operation
- Storage: NREGS-1 words of WIDTH (registers 1..NREGS-1); register 0 has no storage, always reads 0, never pending.
- Write: on posedge Clk with ResetN=1 and RegWrite=1 and WriteRegister≠0, reg[WriteRegister] ← WriteData and pending[WriteRegister] ← 0. RegWrite=0 or WriteRegister=0: no state change. Only the addressed register changes.
- Read: ReadDataN = reg[ReadRegisterN] combinationally; 0 when address is 0. Both ports independent; same address on both returns identical data.
- Scoreboard: one pending bit per register 1..NREGS-1. BusyN = pending[ReadRegisterN]; 0 for address 0.
- Reserve: ReserveAck = Reserve & (ReserveRegister≠0) & ~pending[ReserveRegister]. On posedge with ReserveAck=1, pending[ReserveRegister] ← 1. Reserve of an already-pending register is refused (ReserveAck=0, no change); issue logic retries.
- Reserve and write to the same register on one edge: write data is stored, pending ends 1 (new reservation wins over clearing). ReserveAck evaluates against the pre-edge pending bit.
- Write to a non-pending register is legal; pending stays 0.
- Reset: ResetN=0 at posedge clears all registers to 0 and all pending bits to 0; writes and reserves in that cycle are ignored. Reset mid-sequence discards all outstanding reservations.

## Timing
- Write latency: data visible on ReadDataN combinationally after the posedge that performs the write (same-cycle read returns old value unless bypass enabled).
- Scoreboard latency: pending set/clear visible on BusyN after the posedge.
- ReserveAck, ReadDataN, BusyN: combinational from inputs and state, no registered outputs.
- After reset edge: ReadData1=ReadData2=0, Busy1=Busy2=0, ReserveAck follows Reserve & (ReserveRegister≠0).
- Before first reset, state is undefined; the bench must apply ResetN=0 for ≥1 edge.

## Configuration
- REGFILE_BYPASS_EN defined: when RegWrite=1, WriteRegister≠0 and ReadRegisterN==WriteRegister, ReadDataN = WriteData and BusyN = 0 in the same cycle (write-through forwarding, also masks the pending bit being cleared). If Reserve also targets that register in the same cycle, BusyN is still 0 this cycle and 1 after the edge.
- Undefined: no forwarding; reads and Busy reflect stored state only, one edge behind the write.

## Test plan
- Reset then read all addresses on both ports -> every ReadData = 0, Busy = 0.
- Write 42 to r2, then 15 to r2, read r2 on both ports -> 42 then 15; r1 and r3 read 0 (decoder isolation).
- RegWrite=0 with WriteRegister=2, WriteData=30 -> r2 still 15; write 15 to r0 -> ReadData1 at address 0 = 0.
- Write 30 to r17, ReadRegister1=2, ReadRegister2=17 -> ReadData1=15, ReadData2=30 (ports independent, no port hardwired).
- Reserve r5 -> ReserveAck=1, next cycle Busy1=1 at r5; second Reserve r5 -> ReserveAck=0; write 7 to r5 -> Busy1=0, ReadData1=7; same-edge write+reserve on r6 -> Busy=1 after edge; reserve r0 -> ReserveAck=0.
- With REGFILE_BYPASS_EN: RegWrite=1, r9←0xDEADBEEF, ReadRegister1=9 before the edge -> ReadData1=0xDEADBEEF same cycle; without macro -> old value until after edge. Assert ResetN=0 with pending r5 -> Busy=0, r9 reads 0.
